// File: rtl/mips_register_hazard_scoreboard_if.sv
// Decode-side bundle between the decode stage and the register hazard scoreboard.
// Performance counter signals exist only with MIPS_REGISTER_HAZARD_SCOREBOARD_PERF_EN.
interface mips_register_hazard_scoreboard_if #(
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned PERF_WIDTH     = 32
);
    logic                      hold;
    logic                      idValid;
    logic                      idUseRs;
    logic                      idUseRt;
    logic                      idBranchCmp;
    logic [REG_ADDR_WIDTH-1:0] idRs;
    logic [REG_ADDR_WIDTH-1:0] idRt;
    logic                      idWrEnable;
    logic [REG_ADDR_WIDTH-1:0] idWrAddr;
    logic                      idIsLoad;
    logic                      flush;
    logic                      stall;
    logic [1:0]                fwdRs;
    logic [1:0]                fwdRt;
    logic [REG_ADDR_WIDTH-1:0] exDest;
`ifdef MIPS_REGISTER_HAZARD_SCOREBOARD_PERF_EN
    logic [PERF_WIDTH-1:0]     stallCycles;
    logic [PERF_WIDTH-1:0]     loadUseStalls;
    logic [PERF_WIDTH-1:0]     branchStalls;
`endif

    modport master (
        output hold, idValid, idUseRs, idUseRt, idBranchCmp, idRs, idRt,
               idWrEnable, idWrAddr, idIsLoad, flush,
`ifdef MIPS_REGISTER_HAZARD_SCOREBOARD_PERF_EN
        input  stallCycles, loadUseStalls, branchStalls,
`endif
        input  stall, fwdRs, fwdRt, exDest
    );

    modport slave (
        input  hold, idValid, idUseRs, idUseRt, idBranchCmp, idRs, idRt,
               idWrEnable, idWrAddr, idIsLoad, flush,
`ifdef MIPS_REGISTER_HAZARD_SCOREBOARD_PERF_EN
        output stallCycles, loadUseStalls, branchStalls,
`endif
        output stall, fwdRs, fwdRt, exDest
    );
endinterface

// File: rtl/mips_register_hazard_scoreboard.sv
// Decode-stage hazard scoreboard: tracks EX/MEM/WB destinations, drives stall and read-port forwarding.
// Optional stall counters enabled by MIPS_REGISTER_HAZARD_SCOREBOARD_PERF_EN.
module mips_register_hazard_scoreboard #(
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned PERF_WIDTH     = 32
) (
    input  logic [1:0]                         ctrl,
    mips_register_hazard_scoreboard_if.slave   bus
);
    localparam int unsigned AW = REG_ADDR_WIDTH;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    // ctrl packs {clock, reset}
    logic clk;
    logic rst;
    assign clk = ctrl[1];
    assign rst = ctrl[0];

    logic          ex_valid_q,  ex_valid_d,  mem_valid_q, mem_valid_d, wb_valid_q, wb_valid_d;
    logic [AW-1:0] ex_addr_q,   ex_addr_d,   mem_addr_q,  mem_addr_d,  wb_addr_q,  wb_addr_d;
    logic          ex_load_q,   ex_load_d,   mem_load_q,  mem_load_d,  wb_load_q,  wb_load_d;

    logic rs_ex, rt_ex, rs_mem, rt_mem, rs_wb, rt_wb;
    logic load_use_c, branch_c, stall_c;

    function automatic logic hit(input logic used, input logic [AW-1:0] src,
                                 input logic vld, input logic [AW-1:0] addr);
        return used && (src != '0) && vld && (addr == src);
    endfunction

    always_comb begin
        rs_ex  = hit(bus.idUseRs, bus.idRs, ex_valid_q,  ex_addr_q);
        rt_ex  = hit(bus.idUseRt, bus.idRt, ex_valid_q,  ex_addr_q);
        rs_mem = hit(bus.idUseRs, bus.idRs, mem_valid_q, mem_addr_q);
        rt_mem = hit(bus.idUseRt, bus.idRt, mem_valid_q, mem_addr_q);
        rs_wb  = hit(bus.idUseRs, bus.idRs, wb_valid_q,  wb_addr_q);
        rt_wb  = hit(bus.idUseRt, bus.idRt, wb_valid_q,  wb_addr_q);
    end

    // Branch compares happen in decode, so any EX producer or a MEM load is not yet readable.
    always_comb begin
        load_use_c = bus.idValid && !bus.flush && ex_load_q && (rs_ex || rt_ex);
        branch_c   = bus.idValid && !bus.flush && bus.idBranchCmp &&
                     (rs_ex || rt_ex || (mem_load_q && (rs_mem || rt_mem)));
        stall_c    = load_use_c || branch_c;
    end

    always_comb begin
        bus.fwdRs = FWD_RF;
        bus.fwdRt = FWD_RF;
        if (rs_mem && !mem_load_q) bus.fwdRs = FWD_MEM;
        else if (rs_wb)            bus.fwdRs = FWD_WB;
        if (rt_mem && !mem_load_q) bus.fwdRt = FWD_MEM;
        else if (rt_wb)            bus.fwdRt = FWD_WB;
    end

    assign bus.stall  = stall_c;
    assign bus.exDest = ex_valid_q ? ex_addr_q : '0;

    // Shift the shadow pipeline; stalled or flushed decode enters EX as a bubble.
    always_comb begin
        ex_valid_d  = ex_valid_q;
        ex_addr_d   = ex_addr_q;
        ex_load_d   = ex_load_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        mem_load_d  = mem_load_q;
        wb_valid_d  = wb_valid_q;
        wb_addr_d   = wb_addr_q;
        wb_load_d   = wb_load_q;
        if (!bus.hold) begin
            wb_valid_d  = mem_valid_q;
            wb_addr_d   = mem_addr_q;
            wb_load_d   = mem_load_q;
            mem_valid_d = ex_valid_q;
            mem_addr_d  = ex_addr_q;
            mem_load_d  = ex_load_q;
            ex_valid_d  = bus.idValid && bus.idWrEnable && (bus.idWrAddr != '0) &&
                          !stall_c && !bus.flush;
            ex_addr_d   = bus.idWrAddr;
            ex_load_d   = bus.idIsLoad;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q  <= 1'b0;
            ex_addr_q   <= '0;
            ex_load_q   <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_load_q  <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_addr_q   <= '0;
            wb_load_q   <= 1'b0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_addr_q   <= ex_addr_d;
            ex_load_q   <= ex_load_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_load_q  <= mem_load_d;
            wb_valid_q  <= wb_valid_d;
            wb_addr_q   <= wb_addr_d;
            wb_load_q   <= wb_load_d;
        end
    end

`ifdef MIPS_REGISTER_HAZARD_SCOREBOARD_PERF_EN
    logic [PERF_WIDTH-1:0] stall_cycles_q,  stall_cycles_d;
    logic [PERF_WIDTH-1:0] load_use_cnt_q,  load_use_cnt_d;
    logic [PERF_WIDTH-1:0] branch_cnt_q,    branch_cnt_d;

    // A stall with both causes is attributed to load-use only.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        load_use_cnt_d = load_use_cnt_q;
        branch_cnt_d   = branch_cnt_q;
        if (!bus.hold && stall_c) begin
            stall_cycles_d = stall_cycles_q + PERF_WIDTH'(1);
            if (load_use_c) load_use_cnt_d = load_use_cnt_q + PERF_WIDTH'(1);
            else            branch_cnt_d   = branch_cnt_q + PERF_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q <= '0;
            load_use_cnt_q <= '0;
            branch_cnt_q   <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            load_use_cnt_q <= load_use_cnt_d;
            branch_cnt_q   <= branch_cnt_d;
        end
    end

    assign bus.stallCycles   = stall_cycles_q;
    assign bus.loadUseStalls = load_use_cnt_q;
    assign bus.branchStalls  = branch_cnt_q;
`endif

    logic unused_wb_load;
    assign unused_wb_load = wb_load_q;
endmodule

// File: tb/tb_mips_register_hazard_scoreboard.sv
// Directed self-checking bench for mips_register_hazard_scoreboard (default build).
module tb_mips_register_hazard_scoreboard;
    logic clk;
    logic rst;
    int   tests;
    int   fails;

    mips_register_hazard_scoreboard_if #(.REG_ADDR_WIDTH(5), .PERF_WIDTH(32)) bus ();

    mips_register_hazard_scoreboard #(.REG_ADDR_WIDTH(5), .PERF_WIDTH(32)) dut (
        .ctrl ({clk, rst}),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic urs, input logic urt, input logic br,
                          input logic [4:0] rs, input logic [4:0] rt,
                          input logic we, input logic [4:0] wa, input logic ld);
        bus.idValid     = v;
        bus.idUseRs     = urs;
        bus.idUseRt     = urt;
        bus.idBranchCmp = br;
        bus.idRs        = rs;
        bus.idRt        = rt;
        bus.idWrEnable  = we;
        bus.idWrAddr    = wa;
        bus.idIsLoad    = ld;
    endtask

    task automatic idle();
        bus.hold  = 1'b0;
        bus.flush = 1'b0;
        set_id(0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    endtask

    task automatic drain();
        idle();
        repeat (3) step();
    endtask

    task automatic test_reset();
        #1;
        tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL rst_stall got %0d exp 0", bus.stall); end
        tests++; if (bus.fwdRs !== 2'd0) begin fails++; $display("FAIL rst_fwdrs got %0d exp 0", bus.fwdRs); end
        tests++; if (bus.exDest !== 5'd0) begin fails++; $display("FAIL rst_exdest got %0d exp 0", bus.exDest); end
        rst = 1'b0;
        drain();
        // lw $8 into EX, then lw $9,0($8) in decode
        set_id(1, 0, 0, 0, 5'd0, 5'd0, 1, 5'd8, 1);
        step();
        set_id(1, 1, 0, 0, 5'd8, 5'd0, 1, 5'd9, 1);
        #1;
        tests++; if (bus.stall !== 1'b1) begin fails++; $display("FAIL mid_pre_stall got %0d exp 1", bus.stall); end
        tests++; if (bus.exDest !== 5'd8) begin fails++; $display("FAIL mid_pre_exdest got %0d exp 8", bus.exDest); end
        rst = 1'b1;
        #1;
        tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL mid_rst_stall got %0d exp 0", bus.stall); end
        tests++; if (bus.fwdRs !== 2'd0) begin fails++; $display("FAIL mid_rst_fwdrs got %0d exp 0", bus.fwdRs); end
        tests++; if (bus.exDest !== 5'd0) begin fails++; $display("FAIL mid_rst_exdest got %0d exp 0", bus.exDest); end
        step();
        rst = 1'b0;
        #1;
        tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL post_rst_stall got %0d exp 0", bus.stall); end
        tests++; if (bus.fwdRs !== 2'd0) begin fails++; $display("FAIL post_rst_fwdrs got %0d exp 0", bus.fwdRs); end
        tests++; if (bus.exDest !== 5'd0) begin fails++; $display("FAIL post_rst_exdest got %0d exp 0", bus.exDest); end
        drain();
    endtask

    task automatic test_load_use();
        set_id(1, 0, 0, 0, 5'd0, 5'd0, 1, 5'd8, 1);     // lw $8
        step();
        set_id(1, 1, 1, 0, 5'd8, 5'd9, 1, 5'd10, 0);    // add $10,$8,$9
        #1;
        tests++; if (bus.stall !== 1'b1) begin fails++; $display("FAIL lu_stall1 got %0d exp 1", bus.stall); end
        step();
        // load now in MEM: not forwardable from MEM, nothing in WB yet
        tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL lu_stall2 got %0d exp 0", bus.stall); end
        tests++; if (bus.fwdRs !== 2'd0) begin fails++; $display("FAIL lu_fwdrs_mem got %0d exp 0", bus.fwdRs); end
        tests++; if (bus.fwdRt !== 2'd0) begin fails++; $display("FAIL lu_fwdrt got %0d exp 0", bus.fwdRt); end
        tests++; if (bus.exDest !== 5'd0) begin fails++; $display("FAIL lu_bubble got %0d exp 0", bus.exDest); end
        step();
        set_id(1, 1, 1, 0, 5'd8, 5'd9, 1, 5'd11, 0);    // next reader of $8, load in WB
        #1;
        tests++; if (bus.fwdRs !== 2'd2) begin fails++; $display("FAIL lu_fwdrs_wb got %0d exp 2", bus.fwdRs); end
        tests++; if (bus.fwdRt !== 2'd0) begin fails++; $display("FAIL lu_fwdrt_wb got %0d exp 0", bus.fwdRt); end
        tests++; if (bus.exDest !== 5'd10) begin fails++; $display("FAIL lu_exdest got %0d exp 10", bus.exDest); end
        drain();
    endtask

    task automatic test_branch();
        set_id(1, 0, 0, 0, 5'd0, 5'd0, 1, 5'd8, 0);     // add $8
        step();
        set_id(1, 1, 1, 1, 5'd8, 5'd9, 0, 5'd0, 0);     // beq $8,$9
        #1;
        tests++; if (bus.stall !== 1'b1) begin fails++; $display("FAIL br_alu_stall got %0d exp 1", bus.stall); end
        step();
        tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL br_alu_stall2 got %0d exp 0", bus.stall); end
        tests++; if (bus.fwdRs !== 2'd1) begin fails++; $display("FAIL br_alu_fwdrs got %0d exp 1", bus.fwdRs); end
        tests++; if (bus.fwdRt !== 2'd0) begin fails++; $display("FAIL br_alu_fwdrt got %0d exp 0", bus.fwdRt); end
        drain();
        set_id(1, 0, 0, 0, 5'd0, 5'd0, 1, 5'd8, 1);     // lw $8
        step();
        set_id(1, 1, 1, 1, 5'd8, 5'd0, 0, 5'd0, 0);     // beq $8,$0
        #1;
        tests++; if (bus.stall !== 1'b1) begin fails++; $display("FAIL br_ld_stall1 got %0d exp 1", bus.stall); end
        step();
        tests++; if (bus.stall !== 1'b1) begin fails++; $display("FAIL br_ld_stall2 got %0d exp 1", bus.stall); end
        step();
        tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL br_ld_stall3 got %0d exp 0", bus.stall); end
        tests++; if (bus.fwdRs !== 2'd2) begin fails++; $display("FAIL br_ld_fwdrs got %0d exp 2", bus.fwdRs); end
        tests++; if (bus.fwdRt !== 2'd0) begin fails++; $display("FAIL br_ld_fwdrt got %0d exp 0", bus.fwdRt); end
        drain();
    endtask

    task automatic test_reg_zero();
        set_id(1, 1, 1, 0, 5'd1, 5'd2, 1, 5'd0, 0);     // add $0,$1,$2
        step();
        set_id(1, 1, 1, 1, 5'd0, 5'd0, 1, 5'd3, 0);     // add $3,$0,$0 (compare too)
        #1;
        tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL r0_stall got %0d exp 0", bus.stall); end
        tests++; if (bus.fwdRs !== 2'd0) begin fails++; $display("FAIL r0_fwdrs got %0d exp 0", bus.fwdRs); end
        tests++; if (bus.fwdRt !== 2'd0) begin fails++; $display("FAIL r0_fwdrt got %0d exp 0", bus.fwdRt); end
        tests++; if (bus.exDest !== 5'd0) begin fails++; $display("FAIL r0_exdest got %0d exp 0", bus.exDest); end
        drain();
    endtask

    task automatic test_hold_flush();
        set_id(1, 0, 0, 0, 5'd0, 5'd0, 1, 5'd8, 1);     // lw $8
        step();
        set_id(1, 1, 0, 0, 5'd8, 5'd0, 1, 5'd10, 0);    // add $10,$8,$0
        bus.hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++; if (bus.stall !== 1'b1) begin fails++; $display("FAIL hold_stall[%0d] got %0d exp 1", i, bus.stall); end
            tests++; if (bus.exDest !== 5'd8) begin fails++; $display("FAIL hold_exdest[%0d] got %0d exp 8", i, bus.exDest); end
        end
        bus.hold = 1'b0;
        step();
        tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL hold_release got %0d exp 0", bus.stall); end
        tests++; if (bus.exDest !== 5'd0) begin fails++; $display("FAIL hold_bubble got %0d exp 0", bus.exDest); end
        bus.idValid = 1'b0;
        #1;
        tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL invalid_stall got %0d exp 0", bus.stall); end
        drain();
        set_id(1, 0, 0, 0, 5'd0, 5'd0, 1, 5'd8, 1);     // lw $8
        step();
        set_id(1, 1, 0, 1, 5'd8, 5'd0, 1, 5'd10, 0);
        bus.flush = 1'b1;
        #1;
        tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL flush_stall got %0d exp 0", bus.stall); end
        step();
        tests++; if (bus.exDest !== 5'd0) begin fails++; $display("FAIL flush_bubble got %0d exp 0", bus.exDest); end
        drain();
    endtask

    task automatic test_back_to_back();
        set_id(1, 0, 0, 0, 5'd0, 5'd0, 1, 5'd8, 0);     // add $8
        step();
        set_id(1, 1, 0, 0, 5'd8, 5'd0, 1, 5'd9, 0);     // add $9,$8 (EX match handled downstream)
        #1;
        tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL b2b_stall1 got %0d exp 0", bus.stall); end
        tests++; if (bus.fwdRs !== 2'd0) begin fails++; $display("FAIL b2b_fwdrs1 got %0d exp 0", bus.fwdRs); end
        step();
        set_id(1, 1, 1, 0, 5'd8, 5'd9, 1, 5'd10, 0);    // $8 in MEM, $9 in EX
        #1;
        tests++; if (bus.fwdRs !== 2'd1) begin fails++; $display("FAIL b2b_fwdrs2 got %0d exp 1", bus.fwdRs); end
        tests++; if (bus.fwdRt !== 2'd0) begin fails++; $display("FAIL b2b_fwdrt2 got %0d exp 0", bus.fwdRt); end
        tests++; if (bus.exDest !== 5'd9) begin fails++; $display("FAIL b2b_exdest got %0d exp 9", bus.exDest); end
        step();
        set_id(1, 1, 1, 0, 5'd9, 5'd8, 1, 5'd11, 0);    // $9 in MEM, $8 in WB
        #1;
        tests++; if (bus.fwdRs !== 2'd1) begin fails++; $display("FAIL b2b_fwdrs3 got %0d exp 1", bus.fwdRs); end
        tests++; if (bus.fwdRt !== 2'd2) begin fails++; $display("FAIL b2b_fwdrt3 got %0d exp 2", bus.fwdRt); end
        tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL b2b_stall3 got %0d exp 0", bus.stall); end
        drain();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        test_reset();
        test_load_use();
        test_branch();
        test_reg_zero();
        test_hold_flush();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
